// File: rtl/axil_regbank_pkg.sv
// Shared definitions for the AXI4-Lite accelerator register bank: register
// offsets inside a channel's 0x20 window, response codes and FSM state types.
package axil_regbank_pkg;

  localparam logic [4:0] OFS_AP_CTRL   = 5'h00;
  localparam logic [4:0] OFS_IER       = 5'h04;
  localparam logic [4:0] OFS_ISR       = 5'h08;
  localparam logic [4:0] OFS_RD_BASE   = 5'h10;
  localparam logic [4:0] OFS_WR_BASE   = 5'h14;
  localparam logic [4:0] OFS_IN_BYTES  = 5'h18;
  localparam logic [4:0] OFS_OUT_BYTES = 5'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic logic ofs_mapped(input logic [4:0] ofs);
    return ofs inside {OFS_AP_CTRL, OFS_IER, OFS_ISR, OFS_RD_BASE,
                       OFS_WR_BASE, OFS_IN_BYTES, OFS_OUT_BYTES};
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axil_ch_regs.sv
// Register set of one accelerator channel: ap_ctrl start/done/idle, interrupt
// enable/status and the four DDR descriptor words.
module axil_ch_regs
  import axil_regbank_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  wofs_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic [4:0]  rofs_i,
  input  logic        rd_clr_i,
  input  logic        ap_start_done_i,
  input  logic        ap_ready_i,
  input  logic        ap_done_i,
  output logic        start_o,
  output logic        irq_o,
  output logic [31:0] rd_base_o,
  output logic [31:0] wr_base_o,
  output logic [31:0] in_bytes_o,
  output logic [31:0] out_bytes_o,
  output logic [31:0] rdata_o
);

  logic start_q, start_d, idle_q, idle_d, done_q, done_d;
  logic ier_q, ier_d, isr_q, isr_d;
  logic [31:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;
  logic [31:0] in_bytes_q, in_bytes_d, out_bytes_q, out_bytes_d;
  logic ctrl_wr;

  assign ctrl_wr = we_i && (wofs_i == OFS_AP_CTRL) && wstrb_i[0];

  // Later assignments win: software start beats start_done, hardware done beats clears.
  always_comb begin
    start_d     = start_q;
    idle_d      = idle_q;
    done_d      = done_q;
    ier_d       = ier_q;
    isr_d       = isr_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    in_bytes_d  = in_bytes_q;
    out_bytes_d = out_bytes_q;
    if (ap_start_done_i) start_d = 1'b0;
    if (ctrl_wr) start_d = wdata_i[0];
    if (ap_done_i) idle_d = 1'b1;
    if (ctrl_wr && wdata_i[0]) idle_d = 1'b0;
    if (rd_clr_i) done_d = 1'b0;
    if (ap_done_i) done_d = 1'b1;
    if (we_i && (wofs_i == OFS_IER) && wstrb_i[0]) ier_d = wdata_i[0];
    if (we_i && (wofs_i == OFS_ISR) && wstrb_i[0] && wdata_i[0]) isr_d = 1'b0;
    if (ap_done_i) isr_d = 1'b1;
    if (we_i) begin
      case (wofs_i)
        OFS_RD_BASE:   rd_base_d   = apply_strb(rd_base_q, wdata_i, wstrb_i);
        OFS_WR_BASE:   wr_base_d   = apply_strb(wr_base_q, wdata_i, wstrb_i);
        OFS_IN_BYTES:  in_bytes_d  = apply_strb(in_bytes_q, wdata_i, wstrb_i);
        OFS_OUT_BYTES: out_bytes_d = apply_strb(out_bytes_q, wdata_i, wstrb_i);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q     <= 1'b0;
      idle_q      <= 1'b1;
      done_q      <= 1'b0;
      ier_q       <= 1'b0;
      isr_q       <= 1'b0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      in_bytes_q  <= '0;
      out_bytes_q <= '0;
    end else begin
      start_q     <= start_d;
      idle_q      <= idle_d;
      done_q      <= done_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      in_bytes_q  <= in_bytes_d;
      out_bytes_q <= out_bytes_d;
    end
  end

  always_comb begin
    case (rofs_i)
      OFS_AP_CTRL:   rdata_o = {28'h0, ap_ready_i, idle_q, done_q, start_q};
      OFS_IER:       rdata_o = {31'h0, ier_q};
      OFS_ISR:       rdata_o = {31'h0, isr_q};
      OFS_RD_BASE:   rdata_o = rd_base_q;
      OFS_WR_BASE:   rdata_o = wr_base_q;
      OFS_IN_BYTES:  rdata_o = in_bytes_q;
      OFS_OUT_BYTES: rdata_o = out_bytes_q;
      default:       rdata_o = '0;
    endcase
  end

  assign start_o     = start_q;
  assign irq_o       = ier_q & isr_q;
  assign rd_base_o   = rd_base_q;
  assign wr_base_o   = wr_base_q;
  assign in_bytes_o  = in_bytes_q;
  assign out_bytes_o = out_bytes_q;

endmodule

// File: rtl/s_axilite_regbank.sv
// AXI4-Lite slave register bank: write/read FSMs, address decode and read mux
// in front of one axil_ch_regs instance per accelerator channel.
module s_axilite_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                      C_ADDR_WIDTH = 32,
  parameter int                      C_DATA_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = 32'hA000_0000,
  parameter int                      C_CHANNELS   = 4
) (
  input  logic                         I_aclk,
  input  logic                         I_arst,
  input  logic [C_ADDR_WIDTH-1:0]      I_lite_awaddr,
  input  logic                         I_lite_awvalid,
  output logic                         O_lite_awready,
  input  logic [C_DATA_WIDTH-1:0]      I_lite_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]    I_lite_wstrb,
  input  logic                         I_lite_wvalid,
  output logic                         O_lite_wready,
  output logic [1:0]                   O_lite_bresp,
  output logic                         O_lite_bvalid,
  input  logic                         I_lite_bready,
  input  logic [C_ADDR_WIDTH-1:0]      I_lite_araddr,
  input  logic                         I_lite_arvalid,
  output logic                         O_lite_arready,
  output logic [C_DATA_WIDTH-1:0]      O_lite_rdata,
  output logic [1:0]                   O_lite_rresp,
  output logic                         O_lite_rvalid,
  input  logic                         I_lite_rready,
  output logic [C_CHANNELS-1:0]        O_start,
  input  logic [C_CHANNELS-1:0]        I_ap_start_done,
  input  logic [C_CHANNELS-1:0]        I_ap_ready,
  input  logic [C_CHANNELS-1:0]        I_ap_done,
  output logic [32*C_CHANNELS-1:0]     O_ddr_rd_addr,
  output logic [32*C_CHANNELS-1:0]     O_ddr_wr_addr,
  output logic [32*C_CHANNELS-1:0]     O_in_data_bytes,
  output logic [32*C_CHANNELS-1:0]     O_out_data_bytes,
  output logic                         O_irq
);

  function automatic logic addr_hit(input logic [C_ADDR_WIDTH-1:0] a);
    return (a[C_ADDR_WIDTH-1:12] == C_BASE_ADDR[C_ADDR_WIDTH-1:12]) &&
           (int'(32'(a[11:5])) < C_CHANNELS) && ofs_mapped({a[4:2], 2'b00});
  endfunction

  w_state_e                  wstate_q;
  r_state_e                  rstate_q;
  logic                      awready_q, wready_q, aw_have_q, w_have_q, bvalid_q;
  logic                      arready_q, rvalid_q, irq_q;
  logic [1:0]                bresp_q, rresp_q;
  logic [C_ADDR_WIDTH-1:0]   awaddr_q;
  logic [C_DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [C_DATA_WIDTH/8-1:0] wstrb_q;
  logic                      aw_fire, w_fire, aw_got, w_got, ar_fire;
  logic                      w_hit, r_hit, wr_commit, rd_clr;
  logic [4:0]                w_ofs, r_ofs;
  logic [31:0]               ch_rdata [C_CHANNELS];
  logic [31:0]               rd_sel;
  logic [C_CHANNELS-1:0]     irq_src;
  logic                      unused_addr_bits;

  assign aw_fire   = awready_q & I_lite_awvalid;
  assign w_fire    = wready_q & I_lite_wvalid;
  assign aw_got    = aw_have_q | aw_fire;
  assign w_got     = w_have_q | w_fire;
  assign ar_fire   = arready_q & I_lite_arvalid;
  assign w_hit     = addr_hit(awaddr_q);
  assign r_hit     = addr_hit(I_lite_araddr);
  assign w_ofs     = {awaddr_q[4:2], 2'b00};
  assign r_ofs     = {I_lite_araddr[4:2], 2'b00};
  assign wr_commit = (wstate_q == W_EXEC) && w_hit;
  assign rd_clr    = ar_fire && r_hit && (r_ofs == OFS_AP_CTRL);
  assign unused_addr_bits = ^{awaddr_q[1:0], I_lite_araddr[1:0]};

  // AW and W are captured independently; the commit cycle starts once both are held.
  always_ff @(posedge I_aclk or posedge I_arst) begin
    if (I_arst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_fire) awaddr_q <= I_lite_awaddr;
          if (w_fire) begin
            wdata_q <= I_lite_wdata;
            wstrb_q <= I_lite_wstrb;
          end
          if (aw_got && w_got) begin
            wstate_q  <= W_EXEC;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            aw_have_q <= aw_got;
            w_have_q  <= w_got;
            awready_q <= ~aw_got;
            wready_q  <= ~w_got;
          end
        end
        W_EXEC: begin
          wstate_q <= W_RESP;
          bvalid_q <= 1'b1;
          bresp_q  <= w_hit ? RESP_OKAY : RESP_SLVERR;
        end
        W_RESP: begin
          if (I_lite_bready) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int n = 0; n < C_CHANNELS; n++)
      if (I_lite_araddr[11:5] == 7'(n)) rd_sel = ch_rdata[n];
  end

  always_ff @(posedge I_aclk or posedge I_arst) begin
    if (I_arst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_fire) begin
            rstate_q  <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= r_hit ? rd_sel : '0;
            rresp_q   <= r_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (I_lite_rready) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_aclk or posedge I_arst) begin
    if (I_arst) irq_q <= 1'b0;
    else        irq_q <= |irq_src;
  end

  for (genvar n = 0; n < C_CHANNELS; n++) begin : g_ch
    axil_ch_regs u_regs (
      .clk_i           (I_aclk),
      .rst_i           (I_arst),
      .we_i            (wr_commit && (awaddr_q[11:5] == 7'(n))),
      .wofs_i          (w_ofs),
      .wdata_i         (wdata_q),
      .wstrb_i         (wstrb_q),
      .rofs_i          (r_ofs),
      .rd_clr_i        (rd_clr && (I_lite_araddr[11:5] == 7'(n))),
      .ap_start_done_i (I_ap_start_done[n]),
      .ap_ready_i      (I_ap_ready[n]),
      .ap_done_i       (I_ap_done[n]),
      .start_o         (O_start[n]),
      .irq_o           (irq_src[n]),
      .rd_base_o       (O_ddr_rd_addr[32*n +: 32]),
      .wr_base_o       (O_ddr_wr_addr[32*n +: 32]),
      .in_bytes_o      (O_in_data_bytes[32*n +: 32]),
      .out_bytes_o     (O_out_data_bytes[32*n +: 32]),
      .rdata_o         (ch_rdata[n])
    );
  end

  assign O_lite_awready = awready_q;
  assign O_lite_wready  = wready_q;
  assign O_lite_bvalid  = bvalid_q;
  assign O_lite_bresp   = bresp_q;
  assign O_lite_arready = arready_q;
  assign O_lite_rvalid  = rvalid_q;
  assign O_lite_rdata   = rdata_q;
  assign O_lite_rresp   = rresp_q;
  assign O_irq          = irq_q;

endmodule
